// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with a one-entry skid buffer and sync flush.
// Define PIPE_SKID_REG_PERF_EN to add the saturating stall counter output.
module pipe_skid_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rs_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
`ifdef PIPE_SKID_REG_PERF_EN
    output logic [31:0]      stall_cnt_o,
`endif
    output logic [WIDTH-1:0] data_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept;
    logic             fire;

    // Handshake outputs depend on the state register only.
    assign out_valid_o = (state_q != EMPTY);
    assign in_ready_o  = (state_q != FULL);
    assign data_o      = main_q;

    assign accept = in_valid_i & in_ready_o;
    assign fire   = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = RESET_VALUE;
            skid_d  = RESET_VALUE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = data_i;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (accept && fire) begin
                        main_d = data_i;
                    end else if (accept) begin
                        skid_d  = data_i;
                        state_d = FULL;
                    end else if (fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (fire) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rs_n_i) begin
        if (!rs_n_i) begin
            state_q <= EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_SKID_REG_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Flush leaves the count alone; only reset clears it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_o && !out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rs_n_i) begin
        if (!rs_n_i) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
